// File: rtl/prirv32_pkg.sv
// Shared constants for the priRV32 core: widths, sequencer state encoding, trap causes.
package prirv32_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned REG_AW  = 5;
    localparam int unsigned PC_STEP = 4;

    // Sequencer state encoding
    localparam logic [2:0] SEQ_IDLE  = 3'd0;
    localparam logic [2:0] SEQ_FETCH = 3'd1;
    localparam logic [2:0] SEQ_EXEC  = 3'd2;
    localparam logic [2:0] SEQ_WB    = 3'd3;
    localparam logic [2:0] SEQ_TRAP  = 3'd4;

    // Trap cause codes reported on trap_cause_o
    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_FETCH   = 2'd1;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd2;
    localparam logic [1:0] CAUSE_WDOG    = 2'd3;

    // Jump/branch targets must be word aligned (no compressed instructions)
    function automatic logic tgt_misaligned(input logic [XLEN-1:0] tgt);
        return tgt[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/prirv32_wdog.sv
// EXU watchdog: counts enabled cycles and flags the cycle that completes the
// (2**WDOG_W-1)-th consecutive enabled cycle.
module prirv32_wdog #(
    parameter int unsigned WDOG_W = 8
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    // Count value present during the last allowed cycle (2**WDOG_W - 2)
    localparam logic [WDOG_W-1:0] LAST = ~WDOG_W'(1);

    logic [WDOG_W-1:0] cnt_q;

    // Expiry is combinational so the owner can react on the same edge
    always_comb begin
        expire = en && (cnt_q == LAST);
    end

    // Counter: cleared whenever the owner is not waiting, otherwise counts up
    always_ff @(posedge clk_in) begin
        if (!rst_n || clr) begin
            cnt_q <= '0;
        end else if (en && !expire) begin
            cnt_q <= cnt_q + WDOG_W'(1);
        end
    end

endmodule

// File: rtl/prirv32_core_seq.sv
// priRV32 multi-cycle sequencer: owns the PC and walks each instruction through
// FETCH -> EXEC -> WB, driving the IFU handshake, the EXU start pulse and the
// general-register write port. Any fault parks it in TRAP until reset.
module prirv32_core_seq
    import prirv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned WDOG_W   = 8
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic        stall_i,
    output logic        ifu_req_o,
    output logic [31:0] ifu_addr_o,
    input  logic        ifu_ack_i,
    input  logic [31:0] ifu_instr_i,
    input  logic        ifu_err_i,
    output logic        exu_start_o,
    input  logic        exu_done_i,
    input  logic        exu_br_taken_i,
    input  logic [31:0] exu_br_tgt_i,
    input  logic        exu_rd_wen_i,
    input  logic [4:0]  exu_rd_addr_i,
    input  logic [31:0] exu_rd_data_i,
    input  logic        exu_illegal_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        reg_wen_o,
    output logic [4:0]  reg_waddr_o,
    output logic [31:0] reg_wdata_o,
    output logic        trap_o,
    output logic [1:0]  trap_cause_o
);

    logic [2:0]        state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   npc_q, npc_d;
    logic [XLEN-1:0]   instr_q, instr_d;
    logic              req_q, req_d;
    logic              start_q, start_d;
    logic              wen_q, wen_d;
    logic [REG_AW-1:0] waddr_q, waddr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic              trap_q, trap_d;
    logic [1:0]        cause_q, cause_d;

    logic in_exec;
    logic wdog_expire;
    logic exu_result_valid;

    assign in_exec = (state_q == SEQ_EXEC);
    // A done coinciding with our own start pulse cannot belong to this instruction
    assign exu_result_valid = exu_done_i && !start_q;

    prirv32_wdog #(
        .WDOG_W (WDOG_W)
    ) u_wdog (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .clr    (!in_exec),
        .en     (in_exec),
        .expire (wdog_expire)
    );

    // Next-state and datapath decisions for every register of the sequencer
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        npc_d   = npc_q;
        instr_d = instr_q;
        req_d   = req_q;
        start_d = 1'b0;
        wen_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        trap_d  = trap_q;
        cause_d = cause_q;

        case (state_q)
            SEQ_IDLE: begin
                if (!stall_i) begin
                    state_d = SEQ_FETCH;
                    req_d   = 1'b1;
                end
            end

            SEQ_FETCH: begin
                // Request stays up until the IFU answers; stall has no effect here
                if (ifu_ack_i) begin
                    req_d = 1'b0;
                    if (ifu_err_i) begin
                        state_d = SEQ_TRAP;
                        trap_d  = 1'b1;
                        cause_d = CAUSE_FETCH;
                    end else begin
                        instr_d = ifu_instr_i;
                        start_d = 1'b1;
                        state_d = SEQ_EXEC;
                    end
                end
            end

            SEQ_EXEC: begin
                // A real result wins over a watchdog expiry in the same cycle
                if (exu_result_valid) begin
                    if (exu_illegal_i || (exu_br_taken_i && tgt_misaligned(exu_br_tgt_i))) begin
                        state_d = SEQ_TRAP;
                        trap_d  = 1'b1;
                        cause_d = CAUSE_ILLEGAL;
                    end else begin
                        wen_d   = exu_rd_wen_i && (exu_rd_addr_i != '0);
                        waddr_d = exu_rd_addr_i;
                        wdata_d = exu_rd_data_i;
                        npc_d   = exu_br_taken_i ? exu_br_tgt_i : pc_q + XLEN'(PC_STEP);
                        state_d = SEQ_WB;
                    end
                end else if (wdog_expire) begin
                    state_d = SEQ_TRAP;
                    trap_d  = 1'b1;
                    cause_d = CAUSE_WDOG;
                end
            end

            SEQ_WB: begin
                pc_d = npc_q;
                if (stall_i) begin
                    state_d = SEQ_IDLE;
                end else begin
                    state_d = SEQ_FETCH;
                    req_d   = 1'b1;
                end
            end

            SEQ_TRAP: begin
                // Frozen until reset
                req_d = 1'b0;
            end

            default: begin
                state_d = SEQ_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q <= SEQ_IDLE;
            pc_q    <= RESET_PC;
            npc_q   <= RESET_PC;
            instr_q <= '0;
            req_q   <= 1'b0;
            start_q <= 1'b0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            trap_q  <= 1'b0;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            npc_q   <= npc_d;
            instr_q <= instr_d;
            req_q   <= req_d;
            start_q <= start_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            trap_q  <= trap_d;
            cause_q <= cause_d;
        end
    end

    assign ifu_req_o    = req_q;
    assign ifu_addr_o   = pc_q;
    assign pc_o         = pc_q;
    assign instr_o      = instr_q;
    assign exu_start_o  = start_q;
    assign reg_wen_o    = wen_q;
    assign reg_waddr_o  = waddr_q;
    assign reg_wdata_o  = wdata_q;
    assign trap_o       = trap_q;
    assign trap_cause_o = cause_q;

endmodule

// File: tb/tb_prirv32_core_seq.sv
// Bench for prirv32_core_seq: table of instruction transactions with hand-computed
// results, plus directed sequences for reset, fetch error, stall, watchdog and
// reset during execution. Inputs change and outputs are sampled on the falling edge.
module tb_prirv32_core_seq;

    logic        clk_in = 1'b0;
    logic        rst_n;
    logic        stall_i;
    logic        ifu_req_o;
    logic [31:0] ifu_addr_o;
    logic        ifu_ack_i;
    logic [31:0] ifu_instr_i;
    logic        ifu_err_i;
    logic        exu_start_o;
    logic        exu_done_i;
    logic        exu_br_taken_i;
    logic [31:0] exu_br_tgt_i;
    logic        exu_rd_wen_i;
    logic [4:0]  exu_rd_addr_i;
    logic [31:0] exu_rd_data_i;
    logic        exu_illegal_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        reg_wen_o;
    logic [4:0]  reg_waddr_o;
    logic [31:0] reg_wdata_o;
    logic        trap_o;
    logic [1:0]  trap_cause_o;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    prirv32_core_seq #(
        .RESET_PC (32'h0000_0000),
        .WDOG_W   (4)
    ) dut (
        .clk_in         (clk_in),
        .rst_n          (rst_n),
        .stall_i        (stall_i),
        .ifu_req_o      (ifu_req_o),
        .ifu_addr_o     (ifu_addr_o),
        .ifu_ack_i      (ifu_ack_i),
        .ifu_instr_i    (ifu_instr_i),
        .ifu_err_i      (ifu_err_i),
        .exu_start_o    (exu_start_o),
        .exu_done_i     (exu_done_i),
        .exu_br_taken_i (exu_br_taken_i),
        .exu_br_tgt_i   (exu_br_tgt_i),
        .exu_rd_wen_i   (exu_rd_wen_i),
        .exu_rd_addr_i  (exu_rd_addr_i),
        .exu_rd_data_i  (exu_rd_data_i),
        .exu_illegal_i  (exu_illegal_i),
        .instr_o        (instr_o),
        .pc_o           (pc_o),
        .reg_wen_o      (reg_wen_o),
        .reg_waddr_o    (reg_waddr_o),
        .reg_wdata_o    (reg_wdata_o),
        .trap_o         (trap_o),
        .trap_cause_o   (trap_cause_o)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [31:0] pc;         // expected fetch address
        int          ack_wait;   // cycles the IFU keeps the request waiting
        logic [31:0] instr;
        int          done_dly;   // EXEC cycles after the start cycle until done
        logic        taken;
        logic [31:0] tgt;
        logic        rd_wen;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        illegal;
        logic        exp_wen;
        logic [31:0] exp_npc;
        logic        exp_trap;
        logic [1:0]  exp_cause;
        int          exp_cycles; // fetch-to-next-fetch
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_in);
        cyc++;
    endtask

    task automatic clear_exu();
        exu_done_i     = 1'b0;
        exu_br_taken_i = 1'b0;
        exu_br_tgt_i   = '0;
        exu_rd_wen_i   = 1'b0;
        exu_rd_addr_i  = '0;
        exu_rd_data_i  = '0;
        exu_illegal_i  = 1'b0;
    endtask

    // Bounded wait for a fetch request
    task automatic wait_req(input string name);
        for (int i = 0; i < 20 && !ifu_req_o; i++) tick();
        check({name, "_req"}, 32'(ifu_req_o), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        stall_i = 1'b0;
        ifu_ack_i = 1'b0;
        ifu_err_i = 1'b0;
        clear_exu();
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string nm;
        int t0;
        nm = $sformatf("v%0d", idx);
        wait_req(nm);
        check({nm, "_addr"}, ifu_addr_o, v.pc);
        t0 = cyc;
        for (int w = 0; w < v.ack_wait; w++) begin
            tick();
            check({nm, "_req_held"}, 32'(ifu_req_o), 32'd1);
            check({nm, "_addr_held"}, ifu_addr_o, v.pc);
        end
        ifu_ack_i   = 1'b1;
        ifu_instr_i = v.instr;
        tick();
        ifu_ack_i = 1'b0;
        check({nm, "_start"}, 32'(exu_start_o), 32'd1);
        check({nm, "_instr"}, instr_o, v.instr);
        check({nm, "_req_drop"}, 32'(ifu_req_o), 32'd0);
        tick();
        check({nm, "_start_pulse"}, 32'(exu_start_o), 32'd0);
        for (int d = 1; d < v.done_dly; d++) tick();
        exu_done_i     = 1'b1;
        exu_br_taken_i = v.taken;
        exu_br_tgt_i   = v.tgt;
        exu_rd_wen_i   = v.rd_wen;
        exu_rd_addr_i  = v.rd;
        exu_rd_data_i  = v.data;
        exu_illegal_i  = v.illegal;
        tick();
        clear_exu();
        check({nm, "_wen"}, 32'(reg_wen_o), 32'(v.exp_wen));
        check({nm, "_trap"}, 32'(trap_o), 32'(v.exp_trap));
        check({nm, "_cause"}, 32'(trap_cause_o), 32'(v.exp_cause));
        if (v.exp_trap) begin
            for (int i = 0; i < 6; i++) begin
                tick();
                check({nm, "_trap_noreq"}, 32'(ifu_req_o), 32'd0);
            end
            check({nm, "_trap_pc"}, pc_o, v.pc);
            check({nm, "_trap_instr"}, instr_o, v.instr);
            check({nm, "_trap_sticky"}, 32'(trap_o), 32'd1);
        end else begin
            if (v.exp_wen) begin
                check({nm, "_waddr"}, 32'(reg_waddr_o), 32'(v.rd));
                check({nm, "_wdata"}, reg_wdata_o, v.data);
            end
            tick();
            check({nm, "_wen_pulse"}, 32'(reg_wen_o), 32'd0);
            check({nm, "_next_req"}, 32'(ifu_req_o), 32'd1);
            check({nm, "_next_addr"}, ifu_addr_o, v.exp_npc);
            check({nm, "_cycles"}, 32'(cyc - t0), 32'(v.exp_cycles));
        end
    endtask

    initial begin
        vecs[0] = '{32'h0000_0000, 0, 32'h00A0_0293, 1, 1'b0, 32'h0, 1'b1, 5'd5, 32'hDEAD_BEEF,
                    1'b0, 1'b1, 32'h0000_0004, 1'b0, 2'd0, 4};
        vecs[1] = '{32'h0000_0004, 0, 32'h0FC0_006F, 2, 1'b1, 32'h100, 1'b1, 5'd0, 32'h8,
                    1'b0, 1'b0, 32'h0000_0100, 1'b0, 2'd0, 5};
        vecs[2] = '{32'h0000_0100, 2, 32'h0000_0013, 3, 1'b0, 32'h0, 1'b1, 5'd31, 32'h1234_5678,
                    1'b0, 1'b1, 32'h0000_0104, 1'b0, 2'd0, 8};
        vecs[3] = '{32'h0000_0104, 0, 32'h0000_0063, 1, 1'b0, 32'h200, 1'b0, 5'd7, 32'h77,
                    1'b0, 1'b0, 32'h0000_0108, 1'b0, 2'd0, 4};
        vecs[4] = '{32'h0000_0108, 0, 32'hFFFF_F06F, 1, 1'b1, 32'hFFFF_FFFC, 1'b1, 5'd1, 32'h10C,
                    1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 2'd0, 4};
        vecs[5] = '{32'hFFFF_FFFC, 0, 32'h0000_0013, 1, 1'b0, 32'h0, 1'b1, 5'd2, 32'hAA,
                    1'b0, 1'b1, 32'h0000_0000, 1'b0, 2'd0, 4};
        vecs[6] = '{32'h0000_0000, 0, 32'h0020_006F, 1, 1'b1, 32'h102, 1'b1, 5'd3, 32'h4,
                    1'b0, 1'b0, 32'h0, 1'b1, 2'd2, 0};

        ifu_instr_i = '0;
        // Reset: everything zero after three reset clocks
        do_reset();
        check("rst_req", 32'(ifu_req_o), 32'd0);
        check("rst_addr", ifu_addr_o, 32'd0);
        check("rst_pc", pc_o, 32'd0);
        check("rst_instr", instr_o, 32'd0);
        check("rst_start", 32'(exu_start_o), 32'd0);
        check("rst_wen", 32'(reg_wen_o), 32'd0);
        check("rst_waddr", 32'(reg_waddr_o), 32'd0);
        check("rst_wdata", reg_wdata_o, 32'd0);
        check("rst_trap", 32'(trap_o), 32'd0);
        check("rst_cause", 32'(trap_cause_o), 32'd0);
        tick();
        check("rst_first_req", 32'(ifu_req_o), 32'd1);
        check("rst_first_addr", ifu_addr_o, 32'd0);

        // Table: straight line, branch to x0, waits, wrap, misaligned target trap
        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Fetch error
        do_reset();
        wait_req("ferr");
        ifu_ack_i = 1'b1;
        ifu_err_i = 1'b1;
        tick();
        ifu_ack_i = 1'b0;
        ifu_err_i = 1'b0;
        check("ferr_trap", 32'(trap_o), 32'd1);
        check("ferr_cause", 32'(trap_cause_o), 32'd1);
        check("ferr_start", 32'(exu_start_o), 32'd0);
        tick();
        check("ferr_noreq", 32'(ifu_req_o), 32'd0);

        // Done during start cycle ignored; stall in WB parks in IDLE
        do_reset();
        wait_req("stall");
        ifu_ack_i   = 1'b1;
        ifu_instr_i = 32'h0030_0193;
        tick();
        ifu_ack_i = 1'b0;
        check("early_start", 32'(exu_start_o), 32'd1);
        exu_done_i    = 1'b1;
        exu_illegal_i = 1'b1;
        exu_rd_wen_i  = 1'b1;
        exu_rd_addr_i = 5'd9;
        tick();
        clear_exu();
        check("early_done_trap", 32'(trap_o), 32'd0);
        check("early_done_wen", 32'(reg_wen_o), 32'd0);
        exu_done_i    = 1'b1;
        exu_rd_wen_i  = 1'b1;
        exu_rd_addr_i = 5'd3;
        exu_rd_data_i = 32'h33;
        stall_i       = 1'b1;
        tick();
        clear_exu();
        check("stall_wen", 32'(reg_wen_o), 32'd1);
        check("stall_waddr", 32'(reg_waddr_o), 32'd3);
        check("stall_wdata", reg_wdata_o, 32'h33);
        tick();
        check("stall_pc", pc_o, 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("stall_noreq", 32'(ifu_req_o), 32'd0);
            tick();
        end
        stall_i = 1'b0;
        check("stall_still_idle", 32'(ifu_req_o), 32'd0);
        tick();
        check("stall_resume_req", 32'(ifu_req_o), 32'd1);
        check("stall_resume_addr", ifu_addr_o, 32'd4);

        // Watchdog: no done, trap 15 cycles after the start pulse
        begin
            int n;
            ifu_ack_i   = 1'b1;
            ifu_instr_i = 32'h0000_0073;
            tick();
            ifu_ack_i = 1'b0;
            check("wdog_start", 32'(exu_start_o), 32'd1);
            n = 0;
            for (int i = 0; i < 40 && !trap_o; i++) begin
                tick();
                n++;
            end
            check("wdog_trap", 32'(trap_o), 32'd1);
            check("wdog_latency", 32'(n), 32'd15);
            check("wdog_cause", 32'(trap_cause_o), 32'd3);
            check("wdog_noreq", 32'(ifu_req_o), 32'd0);
        end

        // Reset during EXEC: no write, restart at RESET_PC; then illegal instruction
        do_reset();
        tick();
        wait_req("midrst");
        ifu_ack_i   = 1'b1;
        ifu_instr_i = 32'h0040_0213;
        tick();
        ifu_ack_i = 1'b0;
        tick();
        rst_n         = 1'b0;
        exu_done_i    = 1'b1;
        exu_rd_wen_i  = 1'b1;
        exu_rd_addr_i = 5'd4;
        exu_rd_data_i = 32'h44;
        tick();
        clear_exu();
        rst_n = 1'b1;
        check("midrst_wen", 32'(reg_wen_o), 32'd0);
        check("midrst_instr", instr_o, 32'd0);
        check("midrst_pc", pc_o, 32'd0);
        tick();
        check("midrst_wen_after", 32'(reg_wen_o), 32'd0);
        check("midrst_req", 32'(ifu_req_o), 32'd1);
        check("midrst_addr", ifu_addr_o, 32'd0);
        ifu_ack_i   = 1'b1;
        ifu_instr_i = 32'hFFFF_FFFF;
        tick();
        ifu_ack_i = 1'b0;
        tick();
        exu_done_i    = 1'b1;
        exu_illegal_i = 1'b1;
        exu_rd_wen_i  = 1'b1;
        exu_rd_addr_i = 5'd6;
        tick();
        clear_exu();
        check("illegal_trap", 32'(trap_o), 32'd1);
        check("illegal_cause", 32'(trap_cause_o), 32'd2);
        check("illegal_wen", 32'(reg_wen_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
